// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // Index of the last bit of a byte in the 4-bit bit counter.
  localparam logic [3:0] I2C_LAST_BIT = 4'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizers for SCL/SDA plus a previous-value stage, producing
// SCL edge strobes and START/STOP conditions in the clk12M domain.
module i2c_sync_edge (
  input  logic clk12M,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // Reset to the idle-high bus level so leaving reset never fakes an edge.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk12M) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_q      <= scl_sync_q[1];
      sda_q      <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_resp.sv
// I2C target: address match, 8-bit register pointer, write strobes and
// register reads served over open-drain SDA.
module i2c_target_resp
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1D
) (
  input  logic       clk12M,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_sync_edge u_sync (
    .clk12M    (clk12M),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;      // ACK slot: first fall seen / master ACKed
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;
  logic       reg_we_q, reg_we_d;
  logic       inc_pend_q, inc_pend_d;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], sda_s};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    reg_we_d    = 1'b0;
    inc_pend_d  = 1'b0;

    // Post-write increment lands one cycle after the strobe.
    if (inc_pend_q) reg_addr_d = reg_addr_q + 8'd1;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;

        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == I2C_LAST_BIT) begin
              bit_cnt_d = 4'd0;
              ack_d     = 1'b0;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == PTR) begin
                reg_addr_d = rx_byte;
                state_d    = PTR_ACK;
              end else begin
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
                inc_pend_d  = 1'b1;
                state_d     = WDATA_ACK;
              end
            end
          end
        end

        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
                state_d  = RDATA;
                shift_d  = reg_rdata;
                sda_oe_d = ~reg_rdata[7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == I2C_LAST_BIT) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              ack_d     = 1'b0;
              state_d   = RDATA_ACK;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            reg_addr_d = reg_addr_q + 8'd1;
            if (sda_s) state_d = IGNORE;
            else       ack_d   = 1'b1;
          end else if (scl_fall && ack_q) begin
            shift_d   = reg_rdata;
            sda_oe_d  = ~reg_rdata[7];
            bit_cnt_d = 4'd0;
            state_d   = RDATA;
          end
        end

        IGNORE:  sda_oe_d = 1'b0;
        default: state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk12M) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      rw_q        <= I2C_RW_WRITE;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      inc_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      reg_we_q    <= reg_we_d;
      inc_pend_q  <= inc_pend_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_resp.sv
// Directed bench for i2c_target_resp: a bit-banged I2C initiator drives the
// open-drain bus and a small register model answers reads.
`timescale 1ns/1ps
module tb_i2c_target_resp;
  import i2c_pkg::*;

  logic       clk12M = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] we_addr_log[$];
  logic [7:0] we_data_log[$];
  int         oe_cycles = 0;

  always #5 clk12M = ~clk12M;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = (reg_addr == 8'h20) ? 8'h55 :
                     (reg_addr == 8'h21) ? 8'hC3 : 8'h00;

  i2c_target_resp #(.DEV_ADDR(7'h1D)) dut (
    .clk12M    (clk12M),
    .rst       (rst),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(negedge clk12M) begin
    if (reg_we) begin
      we_addr_log.push_back(reg_addr);
      we_data_log.push_back(reg_wdata);
    end
    if (sda_oe) oe_cycles++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk12M);
    #1;
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; clk_wait(6);
      scl_m = 1'b1; clk_wait(6);
    end
    sda_m = 1'b0; clk_wait(6);
    scl_m = 1'b0; clk_wait(2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clk_wait(6);
    scl_m = 1'b1; clk_wait(6);
    sda_m = 1'b1; clk_wait(6);
  endtask

  // One SCL period starting and ending with SCL low; samples mid-high.
  task automatic bit_cycle(input logic drive, output logic sampled);
    sda_m = drive; clk_wait(6);
    scl_m = 1'b1;  clk_wait(4);
    sampled = sda_bus;
    clk_wait(4);
    scl_m = 1'b0;  clk_wait(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(~master_ack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    clk_wait(4);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    rst = 1'b0;
    clk_wait(10);
  endtask

  task automatic test_write();
    logic a;
    int base = we_addr_log.size();
    bus_start();
    write_byte(8'h3A, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_addr_ack: got %b want 1", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
    write_byte(8'h10, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_ptr_ack: got %b want 1", a); end
    write_byte(8'hA5, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_d0_ack: got %b want 1", a); end
    write_byte(8'h3C, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_d1_ack: got %b want 1", a); end
    checks++; if (we_addr_log.size() !== base + 2) begin errors++; $display("FAIL wr_we_count: got %0d want %0d", we_addr_log.size() - base, 2); end
    if (we_addr_log.size() >= base + 2) begin
      checks++; if (we_addr_log[base] !== 8'h10 || we_data_log[base] !== 8'hA5) begin errors++; $display("FAIL wr_first: got %h/%h want 10/a5", we_addr_log[base], we_data_log[base]); end
      checks++; if (we_addr_log[base+1] !== 8'h11 || we_data_log[base+1] !== 8'h3C) begin errors++; $display("FAIL wr_second: got %h/%h want 11/3c", we_addr_log[base+1], we_data_log[base+1]); end
    end
    checks++; if (reg_addr !== 8'h12) begin errors++; $display("FAIL wr_ptr_after: got %h want 12", reg_addr); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] d;
    bus_start();
    write_byte(8'h3A, a);
    write_byte(8'h20, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_ptr_ack: got %b want 1", a); end
    bus_start();
    write_byte(8'h3B, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got %b want 1", a); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL rd_byte0: got %h want 55", d); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd_byte1: got %h want c3", d); end
    clk_wait(4);
    checks++; if (reg_addr !== 8'h22) begin errors++; $display("FAIL rd_ptr_after: got %h want 22", reg_addr); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_nack: got %b want 0", sda_oe); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_bad_addr();
    logic a;
    int oe0 = oe_cycles;
    int we0 = we_addr_log.size();
    bus_start();
    write_byte(8'h3C, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL bad_addr_ack: got %b want 0", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b want 0", busy); end
    write_byte(8'h05, a);
    write_byte(8'h99, a);
    bus_stop();
    checks++; if (oe_cycles !== oe0) begin errors++; $display("FAIL bad_oe_cycles: got %0d want 0", oe_cycles - oe0); end
    checks++; if (we_addr_log.size() !== we0) begin errors++; $display("FAIL bad_we: got %0d want 0", we_addr_log.size() - we0); end
  endtask

  task automatic test_wrap();
    logic a;
    int base = we_addr_log.size();
    bus_start();
    write_byte(8'h3A, a);
    write_byte(8'hFF, a);
    write_byte(8'h01, a);
    write_byte(8'h02, a);
    bus_stop();
    checks++; if (we_addr_log.size() !== base + 2) begin errors++; $display("FAIL wrap_we_count: got %0d want 2", we_addr_log.size() - base); end
    if (we_addr_log.size() >= base + 2) begin
      checks++; if (we_addr_log[base] !== 8'hFF || we_data_log[base] !== 8'h01) begin errors++; $display("FAIL wrap_first: got %h/%h want ff/01", we_addr_log[base], we_data_log[base]); end
      checks++; if (we_addr_log[base+1] !== 8'h00 || we_data_log[base+1] !== 8'h02) begin errors++; $display("FAIL wrap_second: got %h/%h want 00/02", we_addr_log[base+1], we_data_log[base+1]); end
    end
    checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr: got %h want 01", reg_addr); end
  endtask

  task automatic test_stop_abort();
    logic a, s;
    int base = we_addr_log.size();
    bus_start();
    write_byte(8'h3A, a);
    write_byte(8'h40, a);
    bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b1, s);
    bus_stop();
    checks++; if (we_addr_log.size() !== base) begin errors++; $display("FAIL abort_we: got %0d want 0", we_addr_log.size() - base); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL abort_state: got %0d want IDLE", dut.state_q); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    bus_start();
    write_byte(8'h3A, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL abort_next_ack: got %b want 1", a); end
    write_byte(8'h41, a);
    write_byte(8'h77, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL abort_next_data_ack: got %b want 1", a); end
    bus_stop();
    checks++; if (we_addr_log.size() !== base + 1) begin errors++; $display("FAIL abort_next_we: got %0d want 1", we_addr_log.size() - base); end
    if (we_addr_log.size() >= base + 1) begin
      checks++; if (we_addr_log[base] !== 8'h41 || we_data_log[base] !== 8'h77) begin errors++; $display("FAIL abort_next_write: got %h/%h want 41/77", we_addr_log[base], we_data_log[base]); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    int oe0;
    bus_start();
    write_byte(8'h3A, a);
    write_byte(8'h20, a);
    bus_start();
    write_byte(8'h3B, a);
    clk_wait(4);
    // Bit 7 of 0x55 is 0, so the target is pulling SDA low here.
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstrd_pre_oe: got %b want 1", sda_oe); end
    rst = 1'b1;
    clk_wait(1);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstrd_oe: got %b want 0", sda_oe); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rstrd_ptr: got %h want 00", reg_addr); end
    rst = 1'b0;
    oe0 = oe_cycles;
    sda_m = 1'b1; clk_wait(6);
    scl_m = 1'b1; clk_wait(40);
    checks++; if (oe_cycles !== oe0) begin errors++; $display("FAIL rstrd_idle_oe: got %0d want 0", oe_cycles - oe0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrd_busy: got %b want 0", busy); end
    bus_start();
    write_byte(8'h3A, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rstrd_next_ack: got %b want 1", a); end
    bus_stop();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_addr();
    test_wrap();
    test_stop_abort();
    test_reset_mid_read();
    clk_wait(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
